mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024: number of 64-bit words in the attached data memory.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port mem_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the pipeline presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = STUR, 0 = LDUR.
REQ-008 The block SHALL have ports req_addr and req_wdata, input, `REGDATASIZE bits each: the byte address and the store data.
REQ-009 The block SHALL have port resp_valid, output, 1 bit: a response is available.
REQ-010 The block SHALL have port resp_ready, input, 1 bit: the pipeline consumes the response.
REQ-011 The block SHALL have ports resp_rdata (output, `REGDATASIZE bits, load data) and resp_fault (output, 1 bit, access rejected).
REQ-012 The block SHALL have ports mem_read_enable and mem_write_enable, output, 1 bit each: strobes to the data memory.
REQ-013 The block SHALL have ports mem_addr and mem_write_data, output, `REGDATASIZE bits each: address and data to the data memory.
REQ-014 The block SHALL have port mem_read_data, input, `REGDATASIZE bits: data memory output, valid one cycle after a read strobe.

Function
REQ-015 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-016 The block SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid && req_ready, and its fields are registered at that edge.
REQ-017 On acceptance of an in-range access, the FSM SHALL go IDLE->ISSUE; in ISSUE exactly one of mem_read_enable or mem_write_enable SHALL be high for exactly one cycle, with mem_addr and mem_write_data holding the registered request.
REQ-018 For a read, the FSM SHALL go ISSUE->WAIT; in WAIT it SHALL capture mem_read_data into resp_rdata at the end of the cycle, then go WAIT->RESP.
REQ-019 For a write, the FSM SHALL go ISSUE->RESP and SHALL drive resp_rdata to 0.
REQ-020 Latency from the accepting edge to resp_valid high SHALL be 3 cycles for reads and 2 cycles for writes.
REQ-021 In RESP, resp_valid SHALL be high and resp_rdata and resp_fault SHALL be held stable until resp_ready is high at a rising edge; the FSM then goes RESP->IDLE.
REQ-022 A new request SHALL NOT be accepted in the cycle the response is consumed (no overlap); at most one access is outstanding.
REQ-023 An address with req_addr >= MEM_WORDS*8 SHALL be a fault: no memory strobe is issued, the FSM goes IDLE->RESP, resp_fault=1 and resp_rdata=0, with a latency of 1 cycle.
REQ-024 mem_read_enable and mem_write_enable SHALL never be high simultaneously and SHALL be low in every state except ISSUE.
REQ-025 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-026 req_* changes while not in IDLE SHALL be ignored.

Reset
REQ-027 While reset_n is low, the FSM SHALL be in IDLE, with req_ready=1 and resp_valid, resp_fault, resp_rdata, mem_read_enable, mem_write_enable, mem_addr and mem_write_data all 0.
REQ-028 Reset mid-operation SHALL abandon the access immediately (asynchronously) with no strobe completing after reset_n falls; a read in flight produces no response.
REQ-029 The first request SHALL be acceptable on the first rising edge after reset_n rises.

Configuration
REQ-030 The block SHALL implement macro MEM_ACCESS_ALIGN_CHECK_EN.
REQ-031 With MEM_ACCESS_ALIGN_CHECK_EN defined, req_addr[2:0] != 0 SHALL be a fault handled per REQ-023.
REQ-032 Without MEM_ACCESS_ALIGN_CHECK_EN, the low address bits SHALL pass unchanged to mem_addr, and no alignment fault SHALL exist.

Verification
REQ-033 The bench SHALL cover: store addr 0x10, data 0xDEAD_BEEF -> one cycle with mem_write_enable=1, mem_addr=0x10; resp_valid 2 cycles after acceptance, resp_fault=0.
REQ-034 The bench SHALL cover: load addr 0x10 after that store -> one mem_read_enable cycle; resp_valid 3 cycles after acceptance with resp_rdata=0xDEAD_BEEF.
REQ-035 The bench SHALL cover: load addr 0x2000 with MEM_WORDS=1024 -> no strobes; resp_valid 1 cycle after acceptance with resp_fault=1 and resp_rdata=0.
REQ-036 The bench SHALL cover: resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, and no strobes throughout.
REQ-037 The bench SHALL cover: load addr 0x0C -> fault when MEM_ACCESS_ALIGN_CHECK_EN is defined; otherwise mem_addr=0x0C and the read proceeds.
REQ-038 The bench SHALL cover: reset_n pulsed low during WAIT -> all outputs 0 and req_ready=1 immediately, with no resp_valid afterwards.

Source files
------------

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit sequencing IDLE->ISSUE->WAIT->RESP toward a 64-bit data memory.
// Build option: define MEM_ACCESS_ALIGN_CHECK_EN to fault byte addresses that are not 8-byte aligned.
`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif

module mem_access_unit_checker (
  input logic clk,
  input logic rst_n,
  input logic rd_en,
  input logic wr_en,
  input logic req_ready,
  input logic resp_valid
);
  assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && wr_en));
  assert property (@(posedge clk) disable iff (!rst_n) req_ready |-> !(rd_en || wr_en || resp_valid));
  assert property (@(posedge clk) disable iff (!rst_n) (rd_en || wr_en) |=> !(rd_en || wr_en));
endmodule

module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                      mem_clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [`REGDATASIZE-1:0]   req_addr,
  input  logic [`REGDATASIZE-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [`REGDATASIZE-1:0]   resp_rdata,
  output logic                      resp_fault,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [`REGDATASIZE-1:0]   mem_addr,
  output logic [`REGDATASIZE-1:0]   mem_write_data,
  input  logic [`REGDATASIZE-1:0]   mem_read_data
);
  localparam int DW = `REGDATASIZE;
  localparam logic [DW-1:0] ADDR_LIMIT = DW'(MEM_WORDS * 32'd8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic            write_r;
  logic            req_ready_r;
  logic            resp_valid_r;
  logic            resp_fault_r;
  logic [DW-1:0]   resp_rdata_r;
  logic            mem_read_enable_r;
  logic            mem_write_enable_r;
  logic [DW-1:0]   mem_addr_r;
  logic [DW-1:0]   mem_write_data_r;

  function automatic logic addr_fault(input logic [DW-1:0] addr);
    logic fault;
    fault = (addr >= ADDR_LIMIT);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    fault = fault | (addr[2:0] != 3'b000);
`endif
    return fault;
  endfunction

  // Access sequencer: every output is a register updated here.
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r            <= IDLE;
      write_r            <= 1'b0;
      req_ready_r        <= 1'b1;
      resp_valid_r       <= 1'b0;
      resp_fault_r       <= 1'b0;
      resp_rdata_r       <= {DW{1'b0}};
      mem_read_enable_r  <= 1'b0;
      mem_write_enable_r <= 1'b0;
      mem_addr_r         <= {DW{1'b0}};
      mem_write_data_r   <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            write_r     <= req_write;
            if (addr_fault(req_addr)) begin
              // Rejected accesses skip the memory entirely and respond next cycle.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_fault_r <= 1'b1;
              resp_rdata_r <= {DW{1'b0}};
            end else begin
              state_r            <= ISSUE;
              mem_addr_r         <= req_addr;
              mem_write_data_r   <= req_wdata;
              mem_read_enable_r  <= ~req_write;
              mem_write_enable_r <= req_write;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          mem_read_enable_r  <= 1'b0;
          mem_write_enable_r <= 1'b0;
          if (write_r) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= {DW{1'b0}};
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_fault_r <= 1'b0;
          resp_rdata_r <= mem_read_data;
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r            <= IDLE;
          req_ready_r        <= 1'b1;
          resp_valid_r       <= 1'b0;
          resp_fault_r       <= 1'b0;
          mem_read_enable_r  <= 1'b0;
          mem_write_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_r;
  assign resp_valid       = resp_valid_r;
  assign resp_fault       = resp_fault_r;
  assign resp_rdata       = resp_rdata_r;
  assign mem_read_enable  = mem_read_enable_r;
  assign mem_write_enable = mem_write_enable_r;
  assign mem_addr         = mem_addr_r;
  assign mem_write_data   = mem_write_data_r;

  mem_access_unit_checker u_checker (
    .clk        (mem_clk),
    .rst_n      (reset_n),
    .rd_en      (mem_read_enable_r),
    .wr_en      (mem_write_enable_r),
    .req_ready  (req_ready_r),
    .resp_valid (resp_valid_r)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset corner cases and
// random traffic compared against a word-array reference model.
`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif

module tb_mem_access_unit;
  localparam int DW        = `REGDATASIZE;
  localparam int MEM_WORDS = 1024;

  logic          mem_clk    = 1'b0;
  logic          reset_n    = 1'b1;
  logic          req_valid  = 1'b0;
  logic          req_write  = 1'b0;
  logic [DW-1:0] req_addr   = {DW{1'b0}};
  logic [DW-1:0] req_wdata  = {DW{1'b0}};
  logic          resp_ready = 1'b0;
  logic          req_ready, resp_valid, resp_fault, mem_read_enable, mem_write_enable;
  logic [DW-1:0] resp_rdata, mem_addr, mem_write_data;
  logic [DW-1:0] mem_read_data = {DW{1'b0}};

  logic [DW-1:0] dmem [MEM_WORDS] = '{default: {DW{1'b0}}};
  logic [DW-1:0] ref_mem [int];
  int checks = 0;
  int passes = 0;

  typedef struct {
    bit            wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
    logic [DW-1:0] exp_rdata;
    bit            exp_fault;
    int            exp_lat;
  } vec_t;
  vec_t tbl [10];

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .mem_clk          (mem_clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 mem_clk = ~mem_clk;

  // Synchronous data memory with one-cycle read latency.
  always @(posedge mem_clk) begin
    if (mem_write_enable) dmem[mem_addr[12:3]] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= dmem[mem_addr[12:3]];
  end

  function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic bit model_fault(input logic [DW-1:0] a);
    bit f;
    f = (a >= DW'(MEM_WORDS * 8));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((a % 8) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [DW-1:0] a);
    int w;
    w = int'(a / 8);
    return ref_mem.exists(w) ? ref_mem[w] : {DW{1'b0}};
  endfunction

  task automatic scribble();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = DW'({$urandom, $urandom});
    req_wdata = DW'({$urandom, $urandom});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},        DW'(req_ready), DW'(1));
    check({tag, " resp_valid"},       DW'(resp_valid), DW'(0));
    check({tag, " resp_fault"},       DW'(resp_fault), DW'(0));
    check({tag, " resp_rdata"},       resp_rdata, {DW{1'b0}});
    check({tag, " mem_read_enable"},  DW'(mem_read_enable), DW'(0));
    check({tag, " mem_write_enable"}, DW'(mem_write_enable), DW'(0));
    check({tag, " mem_addr"},         mem_addr, {DW{1'b0}});
    check({tag, " mem_write_data"},   mem_write_data, {DW{1'b0}});
  endtask

  // Called right after a falling edge; leaves the bench just after a falling edge.
  task automatic run_txn(input string name, input bit wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata, input int hold,
                         input logic [DW-1:0] exp_rdata, input bit exp_fault, input int exp_lat);
    int first, rd_cnt, wr_cnt;
    first = 0; rd_cnt = 0; wr_cnt = 0;
    check({name, " req_ready before accept"}, DW'(req_ready), DW'(1));
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge mem_clk); #1;
    req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge mem_clk);
      if (mem_read_enable) begin
        rd_cnt++;
        check({name, " read mem_addr"}, mem_addr, addr);
      end
      if (mem_write_enable) begin
        wr_cnt++;
        check({name, " write mem_addr"}, mem_addr, addr);
        check({name, " write data"}, mem_write_data, wdata);
      end
      if (resp_valid) begin
        first = n;
        break;
      end
      scribble();
    end
    check({name, " latency"}, DW'(first), DW'(exp_lat));
    if (first != 0) begin
      check({name, " resp_rdata"}, resp_rdata, exp_rdata);
      check({name, " resp_fault"}, DW'(resp_fault), DW'(exp_fault));
      for (int h = 0; h < hold; h++) begin
        scribble();
        @(negedge mem_clk);
        check({name, " held resp_valid"}, DW'(resp_valid), DW'(1));
        check({name, " held resp_rdata"}, resp_rdata, exp_rdata);
        check({name, " held resp_fault"}, DW'(resp_fault), DW'(exp_fault));
        check({name, " held req_ready"}, DW'(req_ready), DW'(0));
        check({name, " held strobes"}, DW'({mem_read_enable, mem_write_enable}), DW'(0));
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge mem_clk); #1;
      resp_ready = 1'b0;
      check({name, " resp_valid after consume"}, DW'(resp_valid), DW'(0));
      check({name, " req_ready after consume"}, DW'(req_ready), DW'(1));
    end
    check({name, " read strobes"},  DW'(rd_cnt), DW'(!exp_fault && !wr));
    check({name, " write strobes"}, DW'(wr_cnt), DW'(!exp_fault && wr));
    req_valid = 1'b0;
    if (!model_fault(addr) && wr) ref_mem[int'(addr / 8)] = wdata;
    @(negedge mem_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit            r_wr, r_f;
    int            sel;
    logic [DW-1:0] r_a, r_d;

    tbl[0] = '{1'b1, DW'(64'h10),   DW'(64'hDEAD_BEEF),            0, DW'(64'h0),                   1'b0, 2};
    tbl[1] = '{1'b0, DW'(64'h10),   DW'(64'h0),                    0, DW'(64'hDEAD_BEEF),           1'b0, 3};
    tbl[2] = '{1'b0, DW'(64'h2000), DW'(64'h0),                    0, DW'(64'h0),                   1'b1, 1};
    tbl[3] = '{1'b1, DW'(64'h18),   DW'(64'h0123_4567_89AB_CDEF),  5, DW'(64'h0),                   1'b0, 2};
    tbl[4] = '{1'b0, DW'(64'h18),   DW'(64'h0),                    5, DW'(64'h0123_4567_89AB_CDEF), 1'b0, 3};
    tbl[5] = '{1'b1, DW'(64'h08),   DW'(64'hCAFE_F00D),            0, DW'(64'h0),                   1'b0, 2};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    tbl[6] = '{1'b0, DW'(64'h0C),   DW'(64'h0),                    0, DW'(64'h0),                   1'b1, 1};
`else
    tbl[6] = '{1'b0, DW'(64'h0C),   DW'(64'h0),                    0, DW'(64'hCAFE_F00D),           1'b0, 3};
`endif
    tbl[7] = '{1'b1, DW'(64'h1FF8), DW'(64'hA5A5_5A5A_0F0F_F0F0),  0, DW'(64'h0),                   1'b0, 2};
    tbl[8] = '{1'b1, DW'(64'h2000), DW'(64'hBAD),                  3, DW'(64'h0),                   1'b1, 1};
    tbl[9] = '{1'b0, DW'(64'h1FF8), DW'(64'h0),                    2, DW'(64'hA5A5_5A5A_0F0F_F0F0), 1'b0, 3};

    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge mem_clk);
    @(negedge mem_clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
              tbl[i].exp_rdata, tbl[i].exp_fault, tbl[i].exp_lat);

    // Reset asserted while a load sits in WAIT.
    req_valid = 1'b1; req_write = 1'b0; req_addr = DW'(64'h10);
    @(posedge mem_clk); #1;
    req_valid = 1'b0;
    @(negedge mem_clk);
    check("rst_wait issue strobe", DW'(mem_read_enable), DW'(1));
    @(negedge mem_clk);
    reset_n = 1'b0;
    #1 check_reset_outputs("rst_wait async");
    @(negedge mem_clk);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge mem_clk);
      check("rst_wait no response", DW'(resp_valid), DW'(0));
      check("rst_wait no strobe", DW'({mem_read_enable, mem_write_enable}), DW'(0));
    end
    reset_n = 1'b0;
    @(negedge mem_clk);
    reset_n = 1'b1;
    run_txn("first_after_reset", 1'b0, DW'(64'h10), DW'(64'h0), 0, model_read(DW'(64'h10)), 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 9);
      if (sel == 0)      r_a = DW'(MEM_WORDS * 8) + DW'($urandom_range(0, 4095));
      else if (sel == 1) r_a = DW'($urandom_range(0, 15)) * DW'(8) + DW'($urandom_range(1, 7));
      else if (sel == 2) r_a = DW'(MEM_WORDS * 8 - 8);
      else               r_a = DW'($urandom_range(0, 15)) * DW'(8);
      r_d = DW'({$urandom, $urandom});
      r_f = model_fault(r_a);
      run_txn($sformatf("rand%0d", i), r_wr, r_a, r_d, $urandom_range(0, 3),
              (r_f || r_wr) ? {DW{1'b0}} : model_read(r_a), r_f, r_f ? 1 : (r_wr ? 2 : 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
